ddr2_timing_checker: RTL and testbench

Cycle-accurate DDR2 protocol timing monitor that observes the command stream between the controller scheduler and the PHY. It tracks per-bank open/idle state and elapsed cycle counters across NUM_BANKS banks. Every issued command is checked against tRCD, tRP, tRAS, tRC, tRRD, tFAW, tWR, tRTP, tWTR and tRFC, plus a tREFI refresh-overdue watchdog. It reports violations as registered pulses, sticky flags and a saturating count, and never alters the command stream.

---
 rtl/ddr2_pkg.sv | 41 ++++
 rtl/ddr2_bank_timer.sv | 96 +++++++++
 rtl/ddr2_timing_checker.sv | 168 ++++++++++++++++
 tb/tb_ddr2_timing_checker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// Purpose: shared DDR2 command encoding, timing-violation record and cycle helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: ddr2_cmd_t ({RAS#,CAS#,WE#} encoding), ddr2_timing_viol_t (one bit per
// timing rule plus trfc and state), ns_to_cycles() ceiling conversion, TCK_NS.
package ddr2_pkg;

  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } ddr2_cmd_t;

  typedef struct packed {
    logic state_violation;
    logic trfc_violation;
    logic twtr_violation;
    logic trtp_violation;
    logic twr_violation;
    logic tfaw_violation;
    logic trrd_violation;
    logic trc_violation;
    logic tras_violation;
    logic trp_violation;
    logic trcd_violation;
  } ddr2_timing_viol_t;

  // 200 MHz clock period used for the default timing parameters.
  localparam real TCK_NS = 5.0;

  // Smallest whole number of clock cycles that covers ns nanoseconds.
  function automatic int ns_to_cycles(real ns, real tck);
    return int'($ceil(ns / tck));
  endfunction

endpackage

// File: rtl/ddr2_bank_timer.sv
// Purpose: per-bank open/idle state and elapsed counters, with that bank's checks.
// Latency: checks are combinational on the current command; state updates next edge.
// Backpressure: none, passive observer.
// Ports: clk, rst (sync, high); cmd_valid/cmd/hit select a command aimed at this bank;
// is_open = bank state; rp_pending = precharge younger than tRP; chk = bank-local violations.
module ddr2_bank_timer
  import ddr2_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_RAS = 9,
  parameter int T_RC  = 12,
  parameter int T_WR  = 3,
  parameter int T_RTP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  ddr2_cmd_t         cmd,
  input  logic              hit,
  output logic              is_open,
  output logic              rp_pending,
  output ddr2_timing_viol_t chk
);

  localparam logic [CNT_W-1:0] SAT    = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RCD_C  = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] RP_C   = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] RAS_C  = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] RC_C   = CNT_W'(T_RC);
  localparam logic [CNT_W-1:0] WR_C   = CNT_W'(T_WR);
  localparam logic [CNT_W-1:0] RTP_C  = CNT_W'(T_RTP);

  logic [CNT_W-1:0] since_act, since_pre, since_rd, since_wr;
  logic act_hit, rd_hit, wr_hit, pre_hit;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    return (c == SAT) ? c : c + ONE;
  endfunction

  assign act_hit = cmd_valid && hit && (cmd == CMD_ACT);
  assign rd_hit  = cmd_valid && hit && (cmd == CMD_READ);
  assign wr_hit  = cmd_valid && hit && (cmd == CMD_WRITE);
  // Precharging an idle bank is a no-op for the DRAM, so it starts no tRP window.
  assign pre_hit = cmd_valid && hit && (cmd == CMD_PRE) && is_open;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_open   <= 1'b0;
      since_act <= SAT;
      since_pre <= SAT;
      since_rd  <= SAT;
      since_wr  <= SAT;
    end else begin
      since_act <= act_hit ? ONE : bump(since_act);
      since_pre <= pre_hit ? ONE : bump(since_pre);
      since_rd  <= rd_hit  ? ONE : bump(since_rd);
      since_wr  <= wr_hit  ? ONE : bump(since_wr);
      if (act_hit) begin
        is_open <= 1'b1;
      end else if (pre_hit) begin
        is_open <= 1'b0;
      end
    end
  end

  assign rp_pending = (since_pre < RP_C);

  always_comb begin
    chk = '0;
    if (cmd_valid && hit) begin
      case (cmd)
        CMD_ACT: begin
          chk.state_violation = is_open;
          chk.trp_violation   = (since_pre < RP_C);
          chk.trc_violation   = (since_act < RC_C);
        end
        CMD_READ, CMD_WRITE: begin
          chk.state_violation = !is_open;
          chk.trcd_violation  = (since_act < RCD_C);
        end
        CMD_PRE: begin
          if (is_open) begin
            chk.tras_violation = (since_act < RAS_C);
            chk.trtp_violation = (since_rd < RTP_C);
            chk.twr_violation  = (since_wr < WR_C);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ddr2_timing_checker.sv
// Purpose: DDR2 command-stream timing monitor (per-bank and global rules, tREFI watchdog).
// Latency: a command at cycle N is reported (viol_valid/viol/viol_bank/sticky/count) at N+1.
// Backpressure: none, passive observer that never alters the command stream.
// Ports: clk, rst (sync, high); cmd_valid/cmd/cmd_bank/cmd_all observed command;
// viol_clr clears sticky/count; viol_* reports; bank_open state; refresh_overdue watchdog.
module ddr2_timing_checker
  import ddr2_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 16,
  parameter int T_RCD     = ns_to_cycles(15.0, TCK_NS),
  parameter int T_RP      = ns_to_cycles(15.0, TCK_NS),
  parameter int T_RAS     = ns_to_cycles(45.0, TCK_NS),
  parameter int T_RC      = ns_to_cycles(60.0, TCK_NS),
  parameter int T_RRD     = ns_to_cycles(10.0, TCK_NS),
  parameter int T_FAW     = ns_to_cycles(50.0, TCK_NS),
  parameter int T_WR      = ns_to_cycles(15.0, TCK_NS),
  parameter int T_RTP     = ns_to_cycles(7.5, TCK_NS),
  parameter int T_WTR     = ns_to_cycles(7.5, TCK_NS),
  parameter int T_RFC     = ns_to_cycles(127.5, TCK_NS),
  parameter int T_REFI    = ns_to_cycles(7800.0, TCK_NS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  ddr2_cmd_t                    cmd,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  input  logic                         cmd_all,
  input  logic                         viol_clr,
  output logic                         viol_valid,
  output ddr2_timing_viol_t            viol,
  output logic [$clog2(NUM_BANKS)-1:0] viol_bank,
  output ddr2_timing_viol_t            viol_sticky,
  output logic [CNT_W-1:0]             viol_count,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         refresh_overdue
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam logic [CNT_W-1:0] SAT    = '1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RRD_C  = CNT_W'(T_RRD);
  localparam logic [CNT_W-1:0] FAW_C  = CNT_W'(T_FAW);
  localparam logic [CNT_W-1:0] WTR_C  = CNT_W'(T_WTR);
  localparam logic [CNT_W-1:0] RFC_C  = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] REFI_C = CNT_W'(T_REFI);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    return (c == SAT) ? c : c + ONE;
  endfunction

  logic [NUM_BANKS-1:0] hit;
  logic [NUM_BANKS-1:0] rp_pend;
  ddr2_timing_viol_t    bank_chk [NUM_BANKS];
  logic                 pre_all;

  assign pre_all = cmd_all && (cmd == CMD_PRE);

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign hit[g] = pre_all || (cmd_bank == BW'(g));
    ddr2_bank_timer #(
      .CNT_W (CNT_W),
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_RAS (T_RAS),
      .T_RC  (T_RC),
      .T_WR  (T_WR),
      .T_RTP (T_RTP)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd        (cmd),
      .hit        (hit[g]),
      .is_open    (bank_open[g]),
      .rp_pending (rp_pend[g]),
      .chk        (bank_chk[g])
    );
  end

  // Global counters. faw_age[0] is the newest ACT, faw_age[3] the oldest of the last four.
  logic [CNT_W-1:0] since_act_any, since_wr_any, since_ref;
  logic [CNT_W-1:0] faw_age [4];
  logic             ref_seen;
  logic             act_any, wr_any, ref_any, cmd_chk;

  assign act_any = cmd_valid && (cmd == CMD_ACT);
  assign wr_any  = cmd_valid && (cmd == CMD_WRITE);
  assign ref_any = cmd_valid && (cmd == CMD_REF);
  assign cmd_chk = cmd_valid && (cmd != CMD_NOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      since_act_any <= SAT;
      since_wr_any  <= SAT;
      since_ref     <= '0;
      ref_seen      <= 1'b0;
      for (int k = 0; k < 4; k++) faw_age[k] <= SAT;
    end else begin
      since_act_any <= act_any ? ONE : bump(since_act_any);
      since_wr_any  <= wr_any  ? ONE : bump(since_wr_any);
      since_ref     <= ref_any ? ONE : bump(since_ref);
      if (ref_any) ref_seen <= 1'b1;
      if (act_any) begin
        faw_age[0] <= ONE;
        for (int k = 1; k < 4; k++) faw_age[k] <= bump(faw_age[k-1]);
      end else begin
        for (int k = 0; k < 4; k++) faw_age[k] <= bump(faw_age[k]);
      end
    end
  end

  // since_ref starts at 0 for the watchdog, so tRFC is only enforced once a
  // REFRESH has actually been seen; otherwise the first ACT after reset would trip it.
  logic trfc_hit;
  assign trfc_hit = ref_seen && (since_ref < RFC_C);

  ddr2_timing_viol_t chk;
  logic              found;
  logic [CNT_W-1:0]  cnt_base, cnt_next;
  ddr2_timing_viol_t sticky_base;

  always_comb begin
    chk = '0;
    for (int i = 0; i < NUM_BANKS; i++) chk = ddr2_timing_viol_t'(chk | bank_chk[i]);
    if (cmd_chk) begin
      case (cmd)
        CMD_ACT: begin
          chk.trrd_violation = (since_act_any < RRD_C);
          chk.tfaw_violation = (faw_age[3] < FAW_C);
          chk.trfc_violation = trfc_hit;
        end
        CMD_READ: chk.twtr_violation = (since_wr_any < WTR_C);
        CMD_REF: begin
          chk.state_violation = |bank_open;
          chk.trfc_violation  = trfc_hit;
          chk.trp_violation   = |rp_pend;
        end
        CMD_MRS: chk.state_violation = |bank_open;
        default: ;
      endcase
    end
    found       = |chk;
    // Clear applies first, then this cycle's violation lands on the cleared value.
    cnt_base    = viol_clr ? '0 : viol_count;
    cnt_next    = (found && (cnt_base != SAT)) ? cnt_base + ONE : cnt_base;
    sticky_base = viol_clr ? '0 : viol_sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      viol_valid  <= 1'b0;
      viol        <= '0;
      viol_bank   <= '0;
      viol_sticky <= '0;
      viol_count  <= '0;
    end else begin
      viol_valid  <= found;
      viol        <= chk;
      viol_bank   <= found ? cmd_bank : '0;
      viol_sticky <= ddr2_timing_viol_t'(sticky_base | chk);
      viol_count  <= cnt_next;
    end
  end

  assign refresh_overdue = (since_ref > REFI_C);

endmodule

// File: tb/tb_ddr2_timing_checker.sv
`timescale 1ns/1ps
module tb_ddr2_timing_checker;
  import ddr2_pkg::*;

  localparam int NB = 8;
  localparam int BW = 3;
  localparam int CW = 16;
  localparam int T_RCD = 3, T_RP = 3, T_RAS = 9, T_RC = 12, T_RRD = 2, T_FAW = 10;
  localparam int T_WR = 3, T_RTP = 2, T_WTR = 2, T_RFC = 26, T_REFI = 1560;
  localparam int NEVER = -1000000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  ddr2_cmd_t         cmd = CMD_NOP;
  logic [BW-1:0]     cmd_bank = '0;
  logic              cmd_all = 1'b0;
  logic              viol_clr = 1'b0;
  logic              viol_valid;
  ddr2_timing_viol_t viol, viol_sticky;
  logic [BW-1:0]     viol_bank;
  logic [CW-1:0]     viol_count;
  logic [NB-1:0]     bank_open;
  logic              refresh_overdue;

  always #5 clk = ~clk;

  ddr2_timing_checker dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .cmd_all(cmd_all), .viol_clr(viol_clr), .viol_valid(viol_valid), .viol(viol),
    .viol_bank(viol_bank), .viol_sticky(viol_sticky), .viol_count(viol_count),
    .bank_open(bank_open), .refresh_overdue(refresh_overdue)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: absolute timestamps of the last command of each kind.
  int now;
  int last_act [NB], last_pre [NB], last_rd [NB], last_wr [NB];
  int last_act_any, last_wr_any, last_ref, ref_t;
  bit ref_seen;
  bit open_m [NB];
  int act_q [$];
  ddr2_timing_viol_t sticky_m;
  int count_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      last_act[i] = NEVER; last_pre[i] = NEVER; last_rd[i] = NEVER; last_wr[i] = NEVER;
      open_m[i] = 1'b0;
    end
    last_act_any = NEVER; last_wr_any = NEVER; last_ref = NEVER;
    ref_t = 0; ref_seen = 1'b0; act_q.delete();
    sticky_m = '0; count_m = 0; now = 0;
  endfunction

  function automatic ddr2_timing_viol_t model_eval(input ddr2_cmd_t c, input int b, input bit all);
    ddr2_timing_viol_t v = '0;
    bit any_open = 1'b0;
    for (int i = 0; i < NB; i++) any_open |= open_m[i];
    case (c)
      CMD_ACT: begin
        v.state_violation = open_m[b];
        v.trp_violation   = (now - last_pre[b]) < T_RP;
        v.trc_violation   = (now - last_act[b]) < T_RC;
        v.trrd_violation  = (now - last_act_any) < T_RRD;
        if (act_q.size() >= 4) v.tfaw_violation = (now - act_q[act_q.size()-4]) < T_FAW;
        v.trfc_violation  = ref_seen && ((now - last_ref) < T_RFC);
      end
      CMD_READ, CMD_WRITE: begin
        v.state_violation = !open_m[b];
        v.trcd_violation  = (now - last_act[b]) < T_RCD;
        if (c == CMD_READ) v.twtr_violation = (now - last_wr_any) < T_WTR;
      end
      CMD_PRE: begin
        for (int i = 0; i < NB; i++) begin
          if ((all || i == b) && open_m[i]) begin
            if ((now - last_act[i]) < T_RAS) v.tras_violation = 1'b1;
            if ((now - last_rd[i]) < T_RTP)  v.trtp_violation = 1'b1;
            if ((now - last_wr[i]) < T_WR)   v.twr_violation  = 1'b1;
          end
        end
      end
      CMD_REF: begin
        v.state_violation = any_open;
        v.trfc_violation  = ref_seen && ((now - last_ref) < T_RFC);
        for (int i = 0; i < NB; i++) if ((now - last_pre[i]) < T_RP) v.trp_violation = 1'b1;
      end
      CMD_MRS: v.state_violation = any_open;
      default: ;
    endcase
    return v;
  endfunction

  function automatic void model_update(input ddr2_cmd_t c, input int b, input bit all);
    case (c)
      CMD_ACT: begin
        open_m[b] = 1'b1; last_act[b] = now; last_act_any = now; act_q.push_back(now);
      end
      CMD_READ:  last_rd[b] = now;
      CMD_WRITE: begin last_wr[b] = now; last_wr_any = now; end
      CMD_PRE: begin
        for (int i = 0; i < NB; i++) begin
          if ((all || i == b) && open_m[i]) begin open_m[i] = 1'b0; last_pre[i] = now; end
        end
      end
      CMD_REF: begin last_ref = now; ref_seen = 1'b1; ref_t = now; end
      default: ;
    endcase
  endfunction

  // Apply one cycle of stimulus and compare every output for the following cycle.
  task automatic step(input bit v, input ddr2_cmd_t c, input int b, input bit all, input bit clr);
    ddr2_timing_viol_t e;
    logic [NB-1:0] om;
    bit found;
    cmd_valid = v; cmd = c; cmd_bank = BW'(b); cmd_all = all; viol_clr = clr;
    e = '0;
    if (v && c != CMD_NOP) e = model_eval(c, b, all);
    found = |e;
    if (clr) begin sticky_m = '0; count_m = 0; end
    sticky_m = ddr2_timing_viol_t'(sticky_m | e);
    if (found && count_m < 65535) count_m++;
    if (v && c != CMD_NOP) model_update(c, b, all);
    @(posedge clk);
    #1;
    now++;
    cmd_valid = 1'b0; cmd = CMD_NOP; cmd_all = 1'b0; viol_clr = 1'b0;
    for (int i = 0; i < NB; i++) om[i] = open_m[i];
    check("viol_valid", 32'(viol_valid), 32'(found));
    check("viol", 32'(viol), 32'(e));
    check("viol_bank", 32'(viol_bank), found ? 32'(b) : 32'd0);
    check("viol_sticky", 32'(viol_sticky), 32'(sticky_m));
    check("viol_count", 32'(viol_count), 32'(count_m));
    check("bank_open", 32'(bank_open), 32'(om));
    check("refresh_overdue", 32'(refresh_overdue), 32'((now - ref_t) > T_REFI));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_viol_valid"}, 32'(viol_valid), 32'd0);
    check({tag, "_viol"}, 32'(viol), 32'd0);
    check({tag, "_viol_bank"}, 32'(viol_bank), 32'd0);
    check({tag, "_sticky"}, 32'(viol_sticky), 32'd0);
    check({tag, "_count"}, 32'(viol_count), 32'd0);
    check({tag, "_bank_open"}, 32'(bank_open), 32'd0);
    check({tag, "_overdue"}, 32'(refresh_overdue), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = CMD_NOP; cmd_all = 1'b0; viol_clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all_zero("reset");
  endtask

  typedef struct {
    bit                rst_before;
    int                gap;
    ddr2_cmd_t         c;
    int                bank;
    bit                all;
    bit                clr;
    ddr2_timing_viol_t exp_viol;
    int                exp_count;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input bit r, input int g, input ddr2_cmd_t c, input int b,
                              input bit a, input bit cl, input ddr2_timing_viol_t ev, input int ec);
    vec_t t;
    t.rst_before = r; t.gap = g; t.c = c; t.bank = b; t.all = a; t.clr = cl;
    t.exp_viol = ev; t.exp_count = ec;
    return t;
  endfunction

  initial begin
    ddr2_timing_viol_t V0, V_TRCD, V_TFAW, V_WR_RAS, V_STATE, V_TRCD_WTR, V_PRE3, V_TRFC;
    ddr2_cmd_t rc;
    int r, rb;
    bit rv;

    V0 = '0;
    V_TRCD = '0;     V_TRCD.trcd_violation = 1'b1;
    V_TFAW = '0;     V_TFAW.tfaw_violation = 1'b1;
    V_WR_RAS = '0;   V_WR_RAS.twr_violation = 1'b1; V_WR_RAS.tras_violation = 1'b1;
    V_STATE = '0;    V_STATE.state_violation = 1'b1;
    V_TRCD_WTR = '0; V_TRCD_WTR.trcd_violation = 1'b1; V_TRCD_WTR.twtr_violation = 1'b1;
    V_PRE3 = '0;     V_PRE3.tras_violation = 1'b1; V_PRE3.trtp_violation = 1'b1;
                     V_PRE3.twr_violation = 1'b1;
    V_TRFC = '0;     V_TRFC.trfc_violation = 1'b1;

    tbl[0]  = mk(1, 0,  CMD_ACT,   0, 0, 0, V0,         0);
    tbl[1]  = mk(0, 1,  CMD_READ,  0, 0, 0, V_TRCD,     1);
    tbl[2]  = mk(1, 0,  CMD_ACT,   0, 0, 0, V0,         0);
    tbl[3]  = mk(0, 2,  CMD_READ,  0, 0, 0, V0,         0);
    tbl[4]  = mk(1, 0,  CMD_ACT,   0, 0, 0, V0,         0);
    tbl[5]  = mk(0, 1,  CMD_ACT,   1, 0, 0, V0,         0);
    tbl[6]  = mk(0, 1,  CMD_ACT,   2, 0, 0, V0,         0);
    tbl[7]  = mk(0, 1,  CMD_ACT,   3, 0, 0, V0,         0);
    tbl[8]  = mk(0, 1,  CMD_ACT,   4, 0, 0, V_TFAW,     1);
    tbl[9]  = mk(1, 0,  CMD_ACT,   0, 0, 0, V0,         0);
    tbl[10] = mk(0, 1,  CMD_ACT,   1, 0, 0, V0,         0);
    tbl[11] = mk(0, 1,  CMD_ACT,   2, 0, 0, V0,         0);
    tbl[12] = mk(0, 1,  CMD_ACT,   3, 0, 0, V0,         0);
    tbl[13] = mk(0, 3,  CMD_ACT,   4, 0, 0, V0,         0);
    tbl[14] = mk(1, 0,  CMD_ACT,   1, 0, 0, V0,         0);
    tbl[15] = mk(0, 2,  CMD_WRITE, 1, 0, 0, V0,         0);
    tbl[16] = mk(0, 1,  CMD_PRE,   1, 0, 0, V_WR_RAS,   1);
    tbl[17] = mk(1, 0,  CMD_READ,  2, 0, 0, V_STATE,    1);
    tbl[18] = mk(0, 0,  CMD_PRE,   0, 1, 0, V0,         1);
    tbl[19] = mk(1, 0,  CMD_ACT,   0, 0, 0, V0,         0);
    tbl[20] = mk(0, 0,  CMD_WRITE, 0, 0, 0, V_TRCD,     1);
    tbl[21] = mk(0, 0,  CMD_READ,  0, 0, 0, V_TRCD_WTR, 2);
    tbl[22] = mk(0, 0,  CMD_PRE,   0, 0, 0, V_PRE3,     3);
    tbl[23] = mk(0, 0,  CMD_READ,  3, 0, 1, V_STATE,    1);
    tbl[24] = mk(1, 0,  CMD_REF,   0, 0, 0, V0,         0);
    tbl[25] = mk(0, 19, CMD_ACT,   0, 0, 0, V_TRFC,     1);

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].rst_before) do_reset();
      repeat (tbl[i].gap) step(1'b0, CMD_NOP, 0, 1'b0, 1'b0);
      step(1'b1, tbl[i].c, tbl[i].bank, tbl[i].all, tbl[i].clr);
      check($sformatf("vec%0d_viol", i), 32'(viol), 32'(tbl[i].exp_viol));
      check($sformatf("vec%0d_valid", i), 32'(viol_valid), 32'(|tbl[i].exp_viol));
      check($sformatf("vec%0d_count", i), 32'(viol_count), 32'(tbl[i].exp_count));
      if (i == 23) check("clr_sticky_only_new", 32'(viol_sticky), 32'(V_STATE));
    end

    // Refresh watchdog: the last REFRESH was at cycle 0 of this segment.
    while (now < T_REFI) step(1'b0, CMD_NOP, 0, 1'b0, 1'b0);
    check("overdue_at_trefi", 32'(refresh_overdue), 32'd0);
    step(1'b0, CMD_NOP, 0, 1'b0, 1'b0);
    check("overdue_past_trefi", 32'(refresh_overdue), 32'd1);
    step(1'b1, CMD_REF, 0, 1'b0, 1'b0);
    check("overdue_cleared", 32'(refresh_overdue), 32'd0);
    check("ref_with_open_bank", 32'(viol), 32'(V_STATE));

    // Reset asserted while a violating command is presented and a report is showing.
    do_reset();
    step(1'b1, CMD_ACT, 0, 1'b0, 1'b0);
    step(1'b1, CMD_WRITE, 0, 1'b0, 1'b0);
    check("pre_rst_report", 32'(viol_valid), 32'd1);
    rst = 1'b1; cmd_valid = 1'b1; cmd = CMD_READ; cmd_bank = '0;
    @(posedge clk);
    #1;
    rst = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP;
    model_reset();
    check_all_zero("midrst");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      r  = $urandom_range(0, 99);
      rb = $urandom_range(0, NB - 1);
      if (r < 35)      rc = CMD_NOP;
      else if (r < 55) rc = CMD_ACT;
      else if (r < 70) rc = CMD_READ;
      else if (r < 80) rc = CMD_WRITE;
      else if (r < 92) rc = CMD_PRE;
      else if (r < 96) rc = CMD_REF;
      else if (r < 98) rc = CMD_MRS;
      else             rc = CMD_BST;
      rv = ($urandom_range(0, 19) != 0);
      step(rv, rc, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
